// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: bus bundle for the ID/EX pipeline stage.
//
// Carries the decode-side (upstream) handshake and instruction fields, the
// execute-side (downstream) handshake and registered fields, the flush
// request and the stall counter.
//   slave  : the pipeline stage itself (consumes *_in, produces *_out)
//   master : the surrounding core / bench (produces *_in, consumes *_out)
interface id_ex_stage_if #(
    parameter int SIZE        = 32,
    parameter int SIZE_EXTEND = 32,
    parameter int ADDR_SIZE   = 5,
    parameter int SIZE_FNC    = 6,
    parameter int S_WB        = 2,
    parameter int S_M         = 3,
    parameter int S_EX        = 4,
    parameter int CNT_W       = 16
) ();
    logic                   flush;
    // upstream (decode) side
    logic                   in_valid;
    logic                   in_ready;
    logic [S_WB-1:0]        wb_in;
    logic [S_M-1:0]         m_in;
    logic [S_EX-1:0]        ex_in;
    logic [SIZE-1:0]        data_a_in;
    logic [SIZE-1:0]        data_b_in;
    logic [SIZE_EXTEND-1:0] imm_in;
    logic [SIZE-1:0]        jmp_in;
    logic [SIZE_FNC-1:0]    funct_in;
    logic [ADDR_SIZE-1:0]   rs_in;
    logic [ADDR_SIZE-1:0]   rt_in;
    logic [ADDR_SIZE-1:0]   wr1_in;
    logic [ADDR_SIZE-1:0]   wr2_in;
    // downstream (execute) side
    logic                   out_valid;
    logic                   out_ready;
    logic [S_WB-1:0]        wb_out;
    logic [S_M-1:0]         m_out;
    logic [S_EX-1:0]        ex_out;
    logic [SIZE-1:0]        data_a;
    logic [SIZE-1:0]        data_b;
    logic [SIZE_EXTEND-1:0] imm;
    logic [SIZE-1:0]        jmp;
    logic [SIZE_FNC-1:0]    funct;
    logic [ADDR_SIZE-1:0]   rs;
    logic [ADDR_SIZE-1:0]   rt;
    logic [ADDR_SIZE-1:0]   wr1;
    logic [ADDR_SIZE-1:0]   wr2;
    logic [CNT_W-1:0]       stall_cnt;

    modport slave (
        input  flush, in_valid, wb_in, m_in, ex_in, data_a_in, data_b_in,
               imm_in, jmp_in, funct_in, rs_in, rt_in, wr1_in, wr2_in, out_ready,
        output in_ready, out_valid, wb_out, m_out, ex_out, data_a, data_b,
               imm, jmp, funct, rs, rt, wr1, wr2, stall_cnt
    );

    modport master (
        output flush, in_valid, wb_in, m_in, ex_in, data_a_in, data_b_in,
               imm_in, jmp_in, funct_in, rs_in, rt_in, wr1_in, wr2_in, out_ready,
        input  in_ready, out_valid, wb_out, m_out, ex_out, data_a, data_b,
               imm, jmp, funct, rs, rt, wr1, wr2, stall_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the MIPS32 core with valid/ready
// handshake, flush-to-bubble, synchronous reset and a saturating stall counter.
//
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset, overrides flush and transfers
//   bus  - id_ex_stage_if.slave: decode-side in_valid/in_ready and *_in
//          fields, execute-side out_valid/out_ready and registered fields,
//          flush request, stall_cnt
//
// Build option:
//   ID_EX_SKID_EN - when defined, a two-entry skid buffer (EMPTY/ONE/TWO)
//                   with in_ready taken straight from state; when undefined,
//                   a single entry with in_ready combinational from out_ready.
module id_ex_stage #(
    parameter int SIZE        = 32,
    parameter int SIZE_EXTEND = 32,
    parameter int ADDR_SIZE   = 5,
    parameter int SIZE_FNC    = 6,
    parameter int S_WB        = 2,
    parameter int S_M         = 3,
    parameter int S_EX        = 4,
    parameter int CNT_W       = 16
) (
    input logic          clk,
    input logic          rst,
    id_ex_stage_if.slave bus
);
    localparam int BUN_W = S_WB + S_M + S_EX + 3 * SIZE + SIZE_EXTEND
                         + SIZE_FNC + 4 * ADDR_SIZE;

    logic [BUN_W-1:0] in_bundle;
    logic [BUN_W-1:0] main_p1;
    logic             out_valid;
    logic             in_ready;
    logic             accept;
    logic [CNT_W-1:0] stall_cnt_q;

    logic [S_WB-1:0]        wb_p1;
    logic [S_M-1:0]         m_p1;
    logic [S_EX-1:0]        ex_p1;
    logic [SIZE-1:0]        data_a_p1;
    logic [SIZE-1:0]        data_b_p1;
    logic [SIZE_EXTEND-1:0] imm_p1;
    logic [SIZE-1:0]        jmp_p1;
    logic [SIZE_FNC-1:0]    funct_p1;
    logic [ADDR_SIZE-1:0]   rs_p1;
    logic [ADDR_SIZE-1:0]   rt_p1;
    logic [ADDR_SIZE-1:0]   wr1_p1;
    logic [ADDR_SIZE-1:0]   wr2_p1;

    // The whole instruction travels as one vector so fields can never mix.
    assign in_bundle = {bus.wb_in, bus.m_in, bus.ex_in, bus.data_a_in,
                        bus.data_b_in, bus.imm_in, bus.jmp_in, bus.funct_in,
                        bus.rs_in, bus.rt_in, bus.wr1_in, bus.wr2_in};

    // A flushed cycle never captures the incoming instruction.
    assign accept = bus.in_valid && in_ready && !bus.flush;

    // ---- stage boundary: decode -> ID/EX register ----
`ifdef ID_EX_SKID_EN
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]       state_q;
    logic [BUN_W-1:0] skid_p1;

    assign out_valid = (state_q != ST_EMPTY);
    // Depends only on state, so no combinational path from out_ready.
    assign in_ready  = (state_q != ST_TWO);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_p1 <= '0;
            skid_p1 <= '0;
        end else if (bus.flush) begin
            state_q <= ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_p1 <= in_bundle;
                        state_q <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && bus.out_ready) begin
                        main_p1 <= in_bundle;
                    end else if (accept) begin
                        // in_ready was still high while stalled: park it
                        skid_p1 <= in_bundle;
                        state_q <= ST_TWO;
                    end else if (bus.out_ready) begin
                        state_q <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (bus.out_ready) begin
                        main_p1 <= skid_p1;
                        state_q <= ST_ONE;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end
`else
    logic vld_p1;
    logic pop;

    assign out_valid = vld_p1;
    assign in_ready  = !vld_p1 || bus.out_ready;
    assign pop       = vld_p1 && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            main_p1 <= '0;
        end else if (bus.flush) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1  <= 1'b1;
            main_p1 <= in_bundle;
        end else if (pop) begin
            vld_p1 <= 1'b0;
        end
    end
`endif

    // Counts cycles the execute side holds off a valid entry; flush leaves it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (out_valid && !bus.out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    // ---- stage boundary: ID/EX register -> execute ----
    assign {wb_p1, m_p1, ex_p1, data_a_p1, data_b_p1, imm_p1, jmp_p1,
            funct_p1, rs_p1, rt_p1, wr1_p1, wr2_p1} = main_p1;

    // Control groups are forced to zero on a bubble so nothing gets written.
    assign bus.wb_out    = out_valid ? wb_p1 : '0;
    assign bus.m_out     = out_valid ? m_p1  : '0;
    assign bus.ex_out    = out_valid ? ex_p1 : '0;
    assign bus.data_a    = data_a_p1;
    assign bus.data_b    = data_b_p1;
    assign bus.imm       = imm_p1;
    assign bus.jmp       = jmp_p1;
    assign bus.funct     = funct_p1;
    assign bus.rs        = rs_p1;
    assign bus.rt        = rt_p1;
    assign bus.wr1       = wr1_p1;
    assign bus.wr2       = wr2_p1;
    assign bus.out_valid = out_valid;
    assign bus.in_ready  = in_ready;
    assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
`timescale 1ns/1ps
module tb_id_ex_stage;
    localparam int SIZE        = 32;
    localparam int SIZE_EXTEND = 32;
    localparam int ADDR_SIZE   = 5;
    localparam int SIZE_FNC    = 6;
    localparam int S_WB        = 2;
    localparam int S_M         = 3;
    localparam int S_EX        = 4;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [S_WB-1:0]        wb;
        logic [S_M-1:0]         m;
        logic [S_EX-1:0]        ex;
        logic [SIZE-1:0]        a;
        logic [SIZE-1:0]        b;
        logic [SIZE_EXTEND-1:0] imm;
        logic [SIZE-1:0]        jmp;
        logic [SIZE_FNC-1:0]    funct;
        logic [ADDR_SIZE-1:0]   rs;
        logic [ADDR_SIZE-1:0]   rt;
        logic [ADDR_SIZE-1:0]   wr1;
        logic [ADDR_SIZE-1:0]   wr2;
    } bundle_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_ex_stage_if #(.SIZE(SIZE), .SIZE_EXTEND(SIZE_EXTEND), .ADDR_SIZE(ADDR_SIZE),
                     .SIZE_FNC(SIZE_FNC), .S_WB(S_WB), .S_M(S_M), .S_EX(S_EX),
                     .CNT_W(CNT_W)) bus ();

    id_ex_stage #(.SIZE(SIZE), .SIZE_EXTEND(SIZE_EXTEND), .ADDR_SIZE(ADDR_SIZE),
                  .SIZE_FNC(SIZE_FNC), .S_WB(S_WB), .S_M(S_M), .S_EX(S_EX),
                  .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    bundle_t sb[$];
    int      errors  = 0;
    int      checks  = 0;
    int      exp_cnt = 0;
    logic    last_acc;

    task automatic set_in(input logic [31:0] v);
        bus.wb_in     = v[1:0];
        bus.m_in      = v[4:2];
        bus.ex_in     = v[8:5];
        bus.data_a_in = v;
        bus.data_b_in = ~v;
        bus.imm_in    = {v[15:0], v[31:16]} ^ 32'h0F0F_0F0F;
        bus.jmp_in    = v + 32'h0040_0000;
        bus.funct_in  = v[5:0] ^ 6'h2A;
        bus.rs_in     = v[4:0];
        bus.rt_in     = v[8:4];
        bus.wr1_in    = ~v[4:0];
        bus.wr2_in    = v[4:0] + 5'd3;
    endtask

    // One clock: check outputs against the model, advance the scoreboard.
    task automatic cycle();
        bundle_t got, in_b;
        logic exp_valid, exp_ready;
        #2;
        exp_valid = (sb.size() != 0);
`ifdef ID_EX_SKID_EN
        exp_ready = (sb.size() < 2);
`else
        exp_ready = !exp_valid || bus.out_ready;
`endif
        if (!rst) begin
            checks++;
            if (bus.out_valid !== exp_valid) begin
                errors++;
                $display("FAIL out_valid @%0t: got %b want %b", $time, bus.out_valid, exp_valid);
            end
            checks++;
            if (bus.in_ready !== exp_ready) begin
                errors++;
                $display("FAIL in_ready @%0t: got %b want %b", $time, bus.in_ready, exp_ready);
            end
            checks++;
            if (bus.stall_cnt !== CNT_W'(exp_cnt)) begin
                errors++;
                $display("FAIL stall_cnt @%0t: got %0d want %0d", $time, bus.stall_cnt, exp_cnt);
            end
            if (!exp_valid) begin
                checks++;
                if ({bus.wb_out, bus.m_out, bus.ex_out} !== '0) begin
                    errors++;
                    $display("FAIL bubble_ctl @%0t: got wb=%b m=%b ex=%b want 0",
                             $time, bus.wb_out, bus.m_out, bus.ex_out);
                end
            end else begin
                got = {bus.wb_out, bus.m_out, bus.ex_out, bus.data_a, bus.data_b, bus.imm,
                       bus.jmp, bus.funct, bus.rs, bus.rt, bus.wr1, bus.wr2};
                checks++;
                if (got !== sb[0]) begin
                    errors++;
                    $display("FAIL bundle @%0t: got data_a=%h wb=%b m=%b imm=%h want data_a=%h wb=%b m=%b imm=%h",
                             $time, got.a, got.wb, got.m, got.imm, sb[0].a, sb[0].wb, sb[0].m, sb[0].imm);
                end
            end
        end
        in_b = {bus.wb_in, bus.m_in, bus.ex_in, bus.data_a_in, bus.data_b_in, bus.imm_in,
                bus.jmp_in, bus.funct_in, bus.rs_in, bus.rt_in, bus.wr1_in, bus.wr2_in};
        last_acc = bus.in_valid && exp_ready && !bus.flush && !rst;
        if (rst) begin
            sb.delete();
            exp_cnt = 0;
        end else begin
            if (exp_valid && !bus.out_ready && exp_cnt != CNT_MAX) exp_cnt++;
            if (bus.flush) begin
                sb.delete();
            end else begin
                if (exp_valid && bus.out_ready) void'(sb.pop_front());
                if (last_acc) sb.push_back(in_b);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        set_in(32'h99);
        cycle();
        cycle();
        checks++;
        if (bus.out_valid !== 1'b0 || {bus.wb_out, bus.m_out, bus.ex_out} !== '0) begin
            errors++;
            $display("FAIL reset_ctl: got valid=%b wb=%b m=%b ex=%b want all 0",
                     bus.out_valid, bus.wb_out, bus.m_out, bus.ex_out);
        end
        checks++;
        if ({bus.data_a, bus.data_b, bus.imm, bus.jmp} !== '0 || bus.stall_cnt !== '0) begin
            errors++;
            $display("FAIL reset_data: got data_a=%h imm=%h stall_cnt=%0d want 0",
                     bus.data_a, bus.imm, bus.stall_cnt);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] vals [4];
        vals = '{32'h11, 32'h22, 32'h33, 32'h44};
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_in(vals[k]);
            bus.in_valid = 1'b1;
            cycle();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.data_a !== vals[k]) begin
                errors++;
                $display("FAIL stream_%0d: got valid=%b data_a=%h want 1 %h",
                         k, bus.out_valid, bus.data_a, vals[k]);
            end
        end
        bus.in_valid = 1'b0;
        cycle();
        cycle();
    endtask

    task automatic test_stall();
        logic [31:0] vals [4];
        int idx = 0;
        vals = '{32'h51, 32'h52, 32'h53, 32'h54};
        do_reset();
        for (int c = 0; c < 14; c++) begin
            bus.out_ready = !(c >= 1 && c <= 3);
            if (idx < 4) begin
                set_in(vals[idx]);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            cycle();
            if (last_acc) idx++;
            if (c >= 1 && c <= 3) begin
                checks++;
                if (bus.data_a !== 32'h51) begin
                    errors++;
                    $display("FAIL stall_hold_%0d: got data_a=%h want 00000051", c, bus.data_a);
                end
            end
            if (c == 3) begin
                checks++;
                if (bus.stall_cnt !== 4'd3) begin
                    errors++;
                    $display("FAIL stall_cnt3: got %0d want 3", bus.stall_cnt);
                end
            end
        end
        checks++;
        if (idx != 4 || sb.size() != 0) begin
            errors++;
            $display("FAIL stall_drain: got fed=%0d pending=%0d want 4 0", idx, sb.size());
        end
    endtask

    task automatic test_flush();
        do_reset();
        bus.out_ready = 1'b0;
        set_in(32'h60);
        bus.wb_in = 2'b11;
        bus.m_in = 3'b101;
        bus.in_valid = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        cycle();
        checks++;
        if (bus.wb_out !== 2'b11 || bus.m_out !== 3'b101) begin
            errors++;
            $display("FAIL flush_held: got wb=%b m=%b want 11 101", bus.wb_out, bus.m_out);
        end
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        set_in(32'h61);
        cycle();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        if (bus.out_valid !== 1'b0 || {bus.wb_out, bus.m_out, bus.ex_out} !== '0) begin
            errors++;
            $display("FAIL flush_kill: got valid=%b wb=%b m=%b ex=%b want 0",
                     bus.out_valid, bus.wb_out, bus.m_out, bus.ex_out);
        end
        checks++;
        if (bus.stall_cnt !== 4'd2) begin
            errors++;
            $display("FAIL flush_cnt: got %0d want 2", bus.stall_cnt);
        end
        cycle();
        cycle();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop: got valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_priority();
        do_reset();
        bus.out_ready = 1'b0;
        set_in(32'h70);
        bus.in_valid = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        cycle();
        cycle();
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        checks++;
        if (bus.stall_cnt !== 4'd3) begin
            errors++;
            $display("FAIL prio_flush_cnt: got %0d want 3", bus.stall_cnt);
        end
        rst = 1'b1;
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        set_in(32'h71);
        cycle();
        rst = 1'b0;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.stall_cnt !== '0 ||
            {bus.wb_out, bus.m_out, bus.ex_out, bus.data_a, bus.data_b, bus.imm, bus.jmp,
             bus.funct, bus.rs, bus.rt, bus.wr1, bus.wr2} !== '0) begin
            errors++;
            $display("FAIL prio_rst: got valid=%b cnt=%0d data_a=%h wb=%b want all 0",
                     bus.out_valid, bus.stall_cnt, bus.data_a, bus.wb_out);
        end
        cycle();
    endtask

    task automatic test_saturation();
        do_reset();
        bus.out_ready = 1'b0;
        set_in(32'h80);
        bus.in_valid = 1'b1;
        cycle();
        bus.in_valid = 1'b0;
        for (int c = 0; c < 20; c++) cycle();
        checks++;
        if (bus.stall_cnt !== 4'd15) begin
            errors++;
            $display("FAIL saturation: got %0d want 15", bus.stall_cnt);
        end
        bus.out_ready = 1'b1;
        cycle();
        cycle();
    endtask

    task automatic test_bubble();
        logic [31:0] vals [5];
        logic [4:0]  pattern;
        vals = '{32'h91, 32'h92, 32'h0, 32'h93, 32'h94};
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                bus.in_valid = 1'b0;
            end else begin
                set_in(vals[k]);
                bus.in_valid = 1'b1;
            end
            cycle();
            pattern[4-k] = bus.out_valid;
            if (k == 2) begin
                checks++;
                if ({bus.wb_out, bus.m_out, bus.ex_out} !== '0 || bus.data_a !== 32'h92) begin
                    errors++;
                    $display("FAIL bubble_slot: got wb=%b m=%b ex=%b data_a=%h want 0 0 0 00000092",
                             bus.wb_out, bus.m_out, bus.ex_out, bus.data_a);
                end
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (pattern !== 5'b11011) begin
            errors++;
            $display("FAIL bubble_pattern: got %b want 11011", pattern);
        end
        cycle();
        cycle();
    endtask

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        set_in(32'h0);
        #1;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_priority();
        test_saturation();
        test_bubble();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end
endmodule
